// File: rtl/reg_ser_pkg.sv
// Shared definitions for the serial link blocks (serializer and the future
// deserializer): FSM state encoding, default word width, bit-order constants
// and the counter-width helper.
package reg_ser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-order flag values as captured from msb_first on accept.
  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Number of bits needed to count 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit counter for a serial word: counts beats 0..WIDTH-1 and flags the
// terminal count. Clear has priority over increment so a word boundary can
// restart the count in the same cycle it would otherwise advance.
//
// Ports:
//   clk    - system clock
//   resetn - asynchronous active-low reset
//   clear  - force the count back to 0
//   inc    - advance the count by one
//   cnt    - current count
//   last   - cnt is at WIDTH-1
module ser_bit_counter
  import reg_ser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clear,
  input  logic                      inc,
  output logic [clog2(WIDTH)-1:0]   cnt,
  output logic                      last
);

  localparam int              CW       = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   ONE      = CW'(1);

  logic [CW-1:0] cnt_r;

  // Count register: clear wins, otherwise advance on inc, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign last = (cnt_r == LAST_CNT);

endmodule

// File: rtl/reg_serializer.sv
// Parallel-to-serial transmitter. Accepts a WIDTH-bit word on a valid/ready
// handshake and sends it one bit per beat (ser_valid & ser_ready) on a serial
// link, LSB-first or MSB-first as selected by msb_first at accept time.
//
// Optional feature: define REG_SERIALIZER_BACK_TO_BACK_EN to let a new word
// be accepted on the final beat of the current one (zero-bubble streaming).
// Without it a word is only accepted in IDLE, costing one bubble per word.
//
// Ports:
//   clk, resetn      - clock, asynchronous active-low reset
//   in_valid/ready   - parallel word handshake
//   in_data          - parallel word, captured on accept
//   msb_first        - bit order, captured on accept (1 = MSB first)
//   ser_out          - current serial bit
//   ser_valid/ready  - serial beat handshake
//   ser_last         - ser_out is the final bit of the word
//   busy             - a word is in flight
module reg_serializer
  import reg_ser_pkg::*;
#(
  parameter int   WIDTH    = DEFAULT_WIDTH,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = clog2(WIDTH);

  ser_state_e       state_r;
  ser_state_e       state_nxt_s;
  logic [WIDTH-1:0] sreg_r;
  logic             order_r;
  logic [CW-1:0]    cnt_s;
  logic             last_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             beat_s;
  logic             clear_s;

  ser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear_s),
    .inc    (beat_s),
    .cnt    (cnt_s),
    .last   (last_s)
  );

  // Handshake decode and next-state logic.
  always_comb begin
    in_ready_s  = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
      end
      SHIFT: begin
`ifdef REG_SERIALIZER_BACK_TO_BACK_EN
        in_ready_s = last_s & ser_ready;
`else
        in_ready_s = 1'b0;
`endif
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase

    accept_s = in_valid & in_ready_s;
    beat_s   = (state_r == SHIFT) & ser_ready;
    // A new word restarts the count; so does finishing the current one.
    clear_s  = accept_s | (beat_s & last_s);

    if (accept_s) begin
      state_nxt_s = SHIFT;
    end else if (beat_s & last_s) begin
      state_nxt_s = IDLE;
    end else if (state_r == SHIFT) begin
      state_nxt_s = SHIFT;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register and captured bit order: load on accept, shift on beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg_r  <= '0;
      order_r <= ORDER_LSB;
    end else if (accept_s) begin
      sreg_r  <= in_data;
      order_r <= msb_first;
    end else if (beat_s) begin
      if (order_r == ORDER_MSB) begin
        sreg_r <= {sreg_r[WIDTH-2:0], FILL_BIT};
      end else begin
        sreg_r <= {FILL_BIT, sreg_r[WIDTH-1:1]};
      end
    end else begin
      sreg_r <= sreg_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = (state_r == SHIFT);
  assign ser_valid = busy;
  // Driven from registers only; forced low outside a word so the idle line is quiet.
  assign ser_out   = busy ? ((order_r == ORDER_MSB) ? sreg_r[WIDTH-1] : sreg_r[0]) : 1'b0;
  assign ser_last  = busy & last_s;

endmodule

// File: tb/tb_reg_serializer.sv
module tb_reg_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         msb_first;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_last;
  logic         busy;

  always #5 clk = ~clk;

  reg_serializer #(
    .WIDTH    (W),
    .FILL_BIT (1'b0)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .msb_first (msb_first),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  bit bit_q[$];
  bit last_q[$];
  int cyc_q[$];

  int ready_mode = 0;  // 0: always ready, 1: pattern 1,0,0, 2: random
  int cyc        = 0;
  int phase      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected transmission sequence, first bit at [7]: whole-word view.
  function automatic logic [7:0] model_seq(input logic [7:0] d, input bit msb);
    logic [7:0] r;
    if (msb) begin
      r = d;
    end else begin
      r = {<<{d}};
    end
    return r;
  endfunction

  // Ready generation and beat monitor.
  bit  pv = 1'b0, pr = 1'b0, po = 1'b0, pl = 1'b0;
  initial begin
    ser_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       ser_ready = 1'b1;
        1:       ser_ready = (phase % 3 == 0);
        default: ser_ready = ($urandom_range(0, 1) == 1);
      endcase
      phase++;
      #1;
      if (resetn) begin
        if (pv && !pr) begin
          check("no_retract", ser_valid, 1'b1);
          check("stall_out", ser_out, po);
          check("stall_last", ser_last, pl);
        end
        if (ser_valid && ser_ready) begin
          bit_q.push_back(ser_out);
          last_q.push_back(ser_last);
          cyc_q.push_back(cyc);
        end
        pv = ser_valid; pr = ser_ready; po = ser_out; pl = ser_last;
      end else begin
        pv = 1'b0;
      end
    end
  end

  task automatic clear_q();
    bit_q.delete(); last_q.delete(); cyc_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input bit msb);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; msb_first = msb;
    #1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk); #1; t++;
    end
    check("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = 8'($urandom);
    msb_first = ($urandom_range(0, 1) == 1);
    check("first_bit_valid", ser_valid, 1'b1);
  endtask

  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (bit_q.size() < n && t < 500) begin
      @(negedge clk); #2; t++;
    end
    check("beat_timeout", (bit_q.size() >= n), 1'b1);
  endtask

  task automatic get_word(output logic [7:0] seq, output logic [7:0] lasts);
    seq = 8'h00; lasts = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (bit_q.size() > 0) begin
        seq[7-k]   = bit_q.pop_front();
        lasts[7-k] = last_q.pop_front();
        void'(cyc_q.pop_front());
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(posedge clk); #1;
    check({name, "_valid"}, ser_valid, 1'b0);
    check({name, "_in_ready"}, in_ready, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         msb;
    int         mode;
    logic [7:0] exp_seq;
  } vec_t;

  initial begin
    vec_t       vecs[6];
    logic [7:0] seq, lasts, rec, d;
    bit         msb;
    int         c0, c15;

    vecs[0] = '{8'hA5, 1'b0, 0, 8'b10100101};
    vecs[1] = '{8'hA5, 1'b1, 0, 8'b10100101};
    vecs[2] = '{8'h81, 1'b1, 0, 8'b10000001};
    vecs[3] = '{8'h01, 1'b1, 0, 8'b00000001};
    vecs[4] = '{8'hC3, 1'b0, 1, 8'b11000011};
    vecs[5] = '{8'h01, 1'b0, 0, 8'b10000000};

    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; msb_first = 1'b0;
    #1;
    check("rst_valid", ser_valid, 1'b0);
    check("rst_last", ser_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out", ser_out, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      ready_mode = vecs[i].mode;
      clear_q();
      send(vecs[i].data, vecs[i].msb);
      wait_beats(8);
      get_word(seq, lasts);
      check($sformatf("vec%0d_seq", i), seq, vecs[i].exp_seq);
      check($sformatf("vec%0d_last", i), lasts, 8'b00000001);
      for (int k = 0; k < 8; k++) rec[vecs[i].msb ? 7-k : k] = seq[7-k];
      check($sformatf("vec%0d_word", i), rec, vecs[i].data);
      check_idle($sformatf("vec%0d_idle", i));
    end

    // Reset in the middle of a word.
    ready_mode = 0;
    clear_q();
    send(8'hA5, 1'b0);
    wait_beats(3);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("midrst_valid", ser_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out", ser_out, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_q();
    send(8'h3C, 1'b0);
    wait_beats(8);
    get_word(seq, lasts);
    check("midrst_next_seq", seq, 8'b00111100);
    check("midrst_next_last", lasts, 8'b00000001);
    check_idle("midrst_idle");

    // Input changes mid-word, then a pending word with different order.
    clear_q();
    send(8'h96, 1'b0);
    repeat (3) begin
      @(negedge clk);
      in_data = 8'($urandom); msb_first = ($urandom_range(0, 1) == 1);
    end
    send(8'h5A, 1'b1);
    wait_beats(16);
    get_word(seq, lasts);
    check("order_w1_seq", seq, 8'b01101001);
    check("order_w1_last", lasts, 8'b00000001);
    get_word(seq, lasts);
    check("order_w2_seq", seq, 8'b01011010);
    check("order_w2_last", lasts, 8'b00000001);
    check_idle("order_idle");

    // Two words in a row: bubble present only without back-to-back.
    clear_q();
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b0);
    wait_beats(16);
    c0 = cyc_q[0]; c15 = cyc_q[15];
`ifdef REG_SERIALIZER_BACK_TO_BACK_EN
    check("b2b_span", c15 - c0, 15);
`else
    check("b2b_span", c15 - c0, 16);
`endif
    get_word(seq, lasts);
    check("b2b_w1_seq", seq, 8'b11110000);
    check("b2b_w1_last", lasts, 8'b00000001);
    get_word(seq, lasts);
    check("b2b_w2_seq", seq, 8'b00001111);
    check("b2b_w2_last", lasts, 8'b00000001);
    check_idle("b2b_idle");

    // Random words with random backpressure against the model.
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      d   = 8'($urandom);
      msb = ($urandom_range(0, 1) == 1);
      clear_q();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(d, msb);
      wait_beats(8);
      get_word(seq, lasts);
      check($sformatf("rnd%0d_seq", i), seq, model_seq(d, msb));
      check($sformatf("rnd%0d_last", i), lasts, 8'b00000001);
      check_idle($sformatf("rnd%0d_idle", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_serializer.md
Name: reg_serializer

Overview:
- Parallel-to-serial transmitter. It is the opposite end of the team's 8-bit shift register, which takes in serial bits and presents a parallel Q.
- Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per accepted beat on a serial valid/ready link.
- Bit order (LSB-first or MSB-first) is selectable per word.
- Sits between the ALU result path and the serial link that feeds a downstream shift register's D0/shift inputs.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- FILL_BIT, 1'b0, value shifted into the vacated end of the internal shift register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous assertion, active-low; one clock, no other reset.
- in_valid  input  1  parallel word offered.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word; captured on accept.
- msb_first  input  1  bit order; sampled only on accept (1 = MSB first, 0 = LSB first).
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream consumes ser_out this cycle.
- ser_last  output  1  ser_out is the final bit of the word.
- busy  output  1  word in flight (state SHIFT).

Behaviour:
- Registers:
  - sreg[WIDTH-1:0]
  - order flag
  - bit counter cnt, width clog2(WIDTH)
  - state ∈ {IDLE, SHIFT}
- Reset (resetn=0, asynchronous):
  - state=IDLE, sreg=0, cnt=0, order=0.
  - Outputs: in_ready=1 once resetn is released, ser_valid=0, ser_last=0, busy=0, ser_out=0.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&in_ready: sreg<=in_data, order<=msb_first, cnt<=0, state<=SHIFT.
- SHIFT:
  - ser_valid=1, in_ready=0 (see Optional Feature).
  - ser_out = order ? sreg[WIDTH-1] : sreg[0]; combinational from registers, never from inputs.
  - ser_last = (cnt==WIDTH-1).
- Beat = ser_valid&ser_ready, at most one beat per cycle:
  - MSB-first: sreg<={sreg[WIDTH-2:0],FILL_BIT}.
  - LSB-first: sreg<={FILL_BIT,sreg[WIDTH-1:1]}.
  - cnt<=cnt+1.
- Last beat: on a beat with ser_last=1, state<=IDLE and cnt<=0. No wrap beyond WIDTH-1.
- Backpressure: while ser_ready=0, sreg, cnt, ser_out and ser_last hold stable; ser_valid stays 1 (no retraction).
- Latency: the first bit is valid the cycle after accept. A word occupies exactly WIDTH beats, plus one IDLE cycle between words.
- Input stability: in_data and msb_first are ignored outside the accept cycle. in_valid during SHIFT is left pending.
- Reset mid-word: the word is discarded and the block restarts in IDLE; no partial-word recovery.
- busy = (state==SHIFT).

Optional Feature:
- Macro: REG_SERIALIZER_BACK_TO_BACK_EN.
- Defined:
  - in_ready is also 1 in SHIFT when ser_last&ser_ready.
  - An accept in that cycle loads the new word, clears cnt, stays in SHIFT.
  - Result: continuous streaming with zero bubble; sustained throughput is 1 bit/cycle.
- Undefined:
  - in_ready = (state==IDLE) only.
  - One mandatory bubble cycle per word; throughput WIDTH/(WIDTH+1).

Decomposition:
- Shared package reg_ser_pkg holds:
  - state enum (IDLE, SHIFT)
  - default WIDTH constant
  - counter-width function clog2
  - ORDER_LSB/ORDER_MSB constants
- Natural sub-module: ser_bit_counter.
  - Ports: clk, resetn, clear, inc, cnt, last; parameter WIDTH.
  - Holds the bit counter and terminal-count flag; reused by the future deserializer.
- Datapath sreg and FSM stay in the top.

Test Plan:
- Reset: hold resetn=0 mid-word (after 3 beats of 8'hA5) -> ser_valid=0, busy=0, in_ready=1 immediately; next word starts fresh from bit 0.
- LSB-first: in_data=8'hA5, msb_first=0, ser_ready=1 -> ser_out sequence 1,0,1,0,0,1,0,1; ser_last only on the 8th; in_ready=1 the cycle after.
- MSB-first: in_data=8'hA5, msb_first=1 -> sequence 1,0,1,0,0,1,0,1 (A5 is palindromic-check); repeat with 8'h81 MSB-first -> 1,0,0,0,0,0,0,1, and 8'h01 MSB-first -> seven 0s then 1.
- Backpressure: 8'hC3 LSB-first, ser_ready toggles 1,0,0,1,... -> ser_out/ser_last stable during stalls; exactly 8 beats; collected byte == 8'hC3.
- Order sampling: change msb_first and in_data mid-word -> current word unaffected; the new values are used only at the next accept.
- Back-to-back (macro defined): in_valid held 1 with 8'h0F then 8'hF0, ser_ready=1 -> 16 consecutive beats, no bubble, ser_last on beats 8 and 16. With the macro undefined, one ser_valid=0 cycle appears between the words.
